// File: rtl/game_round_scheduler_pkg.sv
// Shared game types: players, board cell kinds and scheduler phases.
// Used by the scheduler, the game player and the renderer.
package game_round_scheduler_pkg;

    localparam int PLAYER_W = 3;

    typedef enum logic [PLAYER_W-1:0] {
        NPC,
        RED,
        BLUE
    } player_t;

    typedef enum logic [1:0] {
        TERRITORY,
        MOUNTAIN,
        CROWN,
        CITY
    } cell_t;

    typedef enum logic [2:0] {
        IDLE,
        TURN,
        SWITCH,
        GROW,
        OVER
    } phase_t;

endpackage

// File: rtl/game_round_scheduler_turn_timer.sv
// Loadable down-counter giving each player a bounded time to move.
// Counting stops at zero so the FSM can see the timeout edge.
module turn_timer #(
    parameter int WIDTH = 25,
    parameter int TICKS = 25_000_000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    localparam logic [WIDTH-1:0] RELOAD = WIDTH'(TICKS - 1);

    assign zero = (count == '0);

    always_ff @(posedge clock) begin
        if (reset || load) begin
            count <= RELOAD;
        end else if (enable && !zero) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/game_round_scheduler.sv
// Round sequencer: RED/BLUE turns with timeout, round counter and
// an end-of-round growth sweep over the board via a scan handshake.
module game_round_scheduler
    import game_round_scheduler_pkg::*;
#(
    parameter int BOARD_WIDTH      = 10,
    parameter int LOG2_BOARD_WIDTH = 4,
    parameter int LOG2_PLAYER_CNT  = PLAYER_W,
    parameter int LOG2_MAX_ROUND   = 12,
    parameter int TURN_TICKS       = 25_000_000,
    parameter int LOG2_TURN_TICKS  = 25,
    parameter int GROWTH_PERIOD    = 25
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        move_req,
    output logic                        move_ack,
    input  logic                        game_over,
    output logic                        scan_valid,
    input  logic                        scan_ready,
    output logic [LOG2_BOARD_WIDTH-1:0] scan_h,
    output logic [LOG2_BOARD_WIDTH-1:0] scan_v,
    output logic                        scan_all,
    output logic [LOG2_PLAYER_CNT-1:0]  current_player,
    output logic [LOG2_MAX_ROUND:0]     round,
    output logic [LOG2_TURN_TICKS-1:0]  turn_ticks_left,
    output logic [2:0]                  phase
);

    localparam int RW = LOG2_MAX_ROUND + 1;
    localparam int GW = $clog2(GROWTH_PERIOD + 1);
    localparam logic [LOG2_BOARD_WIDTH-1:0] EDGE =
        LOG2_BOARD_WIDTH'(BOARD_WIDTH - 1);
    localparam logic [GW-1:0] GROW_LAST = GW'(GROWTH_PERIOD - 1);
    localparam logic [GW-1:0] GROW_INIT = GW'(1 % GROWTH_PERIOD);

    phase_t        state;
    player_t       player;
    logic [GW-1:0] grow_cnt;
    logic [GW-1:0] grow_nxt;
    logic          round_max;
    logic          last_cell;
    logic          handshake;
    logic          timer_load;
    logic          timer_en;
    logic          timer_zero;

    assign phase          = state;
    assign current_player = LOG2_PLAYER_CNT'(player);

    // grow_cnt tracks round mod GROWTH_PERIOD without a divider
    assign grow_nxt  = (grow_cnt == GROW_LAST) ? '0 : grow_cnt + 1'b1;
    assign round_max = &round;
    assign last_cell = (scan_h == EDGE) && (scan_v == EDGE);
    assign handshake = scan_valid && scan_ready;

    assign timer_load = (state == IDLE && start) ||
                        (!game_over && state == SWITCH && player == RED) ||
                        (!game_over && state == GROW && handshake && last_cell);
    assign timer_en   = (state == TURN) && !move_req && !game_over;

    turn_timer #(
        .WIDTH (LOG2_TURN_TICKS),
        .TICKS (TURN_TICKS)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .load   (timer_load),
        .enable (timer_en),
        .count  (turn_ticks_left),
        .zero   (timer_zero)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            player     <= NPC;
            round      <= RW'(1);
            grow_cnt   <= GROW_INIT;
            move_ack   <= 1'b0;
            scan_valid <= 1'b0;
            scan_h     <= '0;
            scan_v     <= '0;
            scan_all   <= 1'b0;
        end else if (game_over && state != IDLE) begin
            state      <= OVER;
            move_ack   <= 1'b0;
            scan_valid <= 1'b0;
        end else begin
            move_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= TURN;
                        player <= RED;
                    end
                end
                TURN: begin
                    if (move_req) begin
                        move_ack <= 1'b1;
                        state    <= SWITCH;
                    end else if (timer_zero) begin
                        state <= SWITCH;
                    end
                end
                SWITCH: begin
                    scan_h <= '0;
                    scan_v <= '0;
                    if (player == RED) begin
                        player <= BLUE;
                        state  <= TURN;
                    end else begin
                        state      <= GROW;
                        scan_valid <= 1'b1;
                        if (!round_max) begin
                            round    <= round + 1'b1;
                            grow_cnt <= grow_nxt;
                            scan_all <= (grow_nxt == '0);
                        end else begin
                            scan_all <= (grow_cnt == '0);
                        end
                    end
                end
                GROW: begin
                    if (handshake) begin
                        if (last_cell) begin
                            scan_valid <= 1'b0;
                            player     <= RED;
                            state      <= TURN;
                        end else if (scan_h == EDGE) begin
                            scan_h <= '0;
                            scan_v <= scan_v + 1'b1;
                        end else begin
                            scan_h <= scan_h + 1'b1;
                        end
                    end
                end
                OVER: begin
                    state <= OVER;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_round_scheduler.sv
// Randomised scoreboard bench: turn plans and sweep order are predicted
// from the game rules and checked by a separate monitor process.
`timescale 1ns/1ps
module tb_game_round_scheduler;
    import game_round_scheduler_pkg::*;

    localparam int BW  = 3;
    localparam int LBW = 4;
    localparam int LPC = 3;
    localparam int LMR = 12;
    localparam int TT  = 8;
    localparam int LTT = 4;
    localparam int GP  = 2;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           start = 1'b0;
    logic           move_req = 1'b0;
    logic           game_over = 1'b0;
    logic           scan_ready = 1'b0;
    logic           move_ack;
    logic           scan_valid;
    logic [LBW-1:0] scan_h;
    logic [LBW-1:0] scan_v;
    logic           scan_all;
    logic [LPC-1:0] current_player;
    logic [LMR:0]   round;
    logic [LTT-1:0] turn_ticks_left;
    logic [2:0]     phase;

    game_round_scheduler #(
        .BOARD_WIDTH      (BW),
        .LOG2_BOARD_WIDTH (LBW),
        .LOG2_PLAYER_CNT  (LPC),
        .LOG2_MAX_ROUND   (LMR),
        .TURN_TICKS       (TT),
        .LOG2_TURN_TICKS  (LTT),
        .GROWTH_PERIOD    (GP)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .move_req        (move_req),
        .move_ack        (move_ack),
        .game_over       (game_over),
        .scan_valid      (scan_valid),
        .scan_ready      (scan_ready),
        .scan_h          (scan_h),
        .scan_v          (scan_v),
        .scan_all        (scan_all),
        .current_player  (current_player),
        .round           (round),
        .turn_ticks_left (turn_ticks_left),
        .phase           (phase)
    );

    always #5 clock = ~clock;

    // kind 0: turn end (a=length); 1: ack (a=player b=round c=ticks);
    // 2: handshake (a=h b=v c=all d=round)
    typedef struct {
        int kind;
        int a;
        int b;
        int c;
        int d;
    } ev_t;

    ev_t q[$];
    int  compared = 0;
    int  mismatched = 0;
    bit  mon_en = 1'b0;
    int  run = 0;
    ev_t me;
    bit  mok;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int k, input int a, input int b,
                        input int c, input int d);
        ev_t e;
        e.kind = k;
        e.a = a;
        e.b = b;
        e.c = c;
        e.d = d;
        q.push_back(e);
    endtask

    task automatic take(input int kind, output ev_t e, output bit ok);
        ok = 1'b0;
        e.kind = -1;
        e.a = 0;
        e.b = 0;
        e.c = 0;
        e.d = 0;
        if (q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_event: got kind %0d, expected none", kind);
        end else begin
            e = q.pop_front();
            check("event_kind", kind, e.kind);
            ok = (kind == e.kind);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows an event.
    always @(negedge clock) begin
        if (mon_en) begin
            if (phase == TURN) begin
                run++;
            end else begin
                if (run > 0) begin
                    take(0, me, mok);
                    if (mok) check("turn_len", run, me.a);
                end
                run = 0;
            end
            if (move_ack) begin
                take(1, me, mok);
                if (mok) begin
                    check("ack_player", int'(current_player), me.a);
                    check("ack_round", int'(round), me.b);
                    check("ack_ticks", int'(turn_ticks_left), me.c);
                end
            end
            if (scan_valid && scan_ready) begin
                take(2, me, mok);
                if (mok) begin
                    check("hs_h", int'(scan_h), me.a);
                    check("hs_v", int'(scan_v), me.b);
                    check("hs_all", int'(scan_all), me.c);
                    check("hs_round", int'(round), me.d);
                end
            end else if (scan_valid) begin
                if (q.size() == 0 || q[0].kind != 2) begin
                    compared++;
                    mismatched++;
                    $display("FAIL stray_scan_valid: got 1, expected 0");
                end else begin
                    check("wait_h", int'(scan_h), q[0].a);
                    check("wait_v", int'(scan_v), q[0].b);
                    check("wait_all", int'(scan_all), q[0].c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_phase"}, int'(phase), int'(IDLE));
        check({tag, "_player"}, int'(current_player), int'(NPC));
        check({tag, "_round"}, int'(round), 1);
        check({tag, "_ticks"}, int'(turn_ticks_left), TT - 1);
        check({tag, "_ack"}, int'(move_ack), 0);
        check({tag, "_valid"}, int'(scan_valid), 0);
        check({tag, "_h"}, int'(scan_h), 0);
        check({tag, "_v"}, int'(scan_v), 0);
        check({tag, "_all"}, int'(scan_all), 0);
    endtask

    initial begin
        int  turn_no = 0;
        int  d = 0;
        int  tcyc = 0;
        int  exp_round = 1;
        int  cyc = 0;
        bit  in_turn = 1'b0;
        bit  red_moves = 1'b1;
        bit  timed_out = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (5) tick();
        check_reset_state("idle");

        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_phase", int'(phase), int'(TURN));
        check("start_player", int'(current_player), int'(RED));
        check("start_ticks", int'(turn_ticks_left), TT - 1);

        forever begin
            if (phase != TURN) in_turn = 1'b0;
            if (exp_round >= 9 && phase == GROW && scan_h == 1 && scan_v == 1)
                break;
            if (cyc >= 5000) begin
                timed_out = 1'b1;
                break;
            end
            if (phase == TURN && !in_turn) begin
                in_turn = 1'b1;
                tcyc = 0;
                if (move_req) d = 0;
                else if (turn_no == 0) d = 2;
                else if (turn_no == 1) d = TT + 1;
                else if (turn_no == 2) d = TT - 1;
                else d = $urandom_range(0, TT + 1);
                push(0, (d < TT) ? d + 1 : TT, 0, 0, 0);
                if (d < TT)
                    push(1, red_moves ? int'(RED) : int'(BLUE),
                         exp_round, TT - 1 - d, 0);
                if (!red_moves) begin
                    exp_round++;
                    for (int v = 0; v < BW; v++)
                        for (int h = 0; h < BW; h++)
                            push(2, h, v, (exp_round % GP == 0) ? 1 : 0,
                                 exp_round);
                end
                red_moves = !red_moves;
                turn_no++;
            end
            if (in_turn) begin
                if (d < TT && tcyc >= d) move_req = 1'b1;
                tcyc++;
            end else begin
                if (move_ack) move_req = 1'b0;
                if (turn_no >= 3 && !move_req && $urandom_range(0, 5) == 0)
                    move_req = 1'b1;
            end
            scan_ready = ($urandom_range(0, 1) == 1);
            tick();
            cyc++;
        end

        if (timed_out) begin
            compared++;
            mismatched++;
            $display("FAIL cycle_budget: got %0d cycles, expected fewer", cyc);
        end else begin
            game_over = 1'b1;
            scan_ready = 1'b0;
            tick();
            check("over_phase", int'(phase), int'(OVER));
            check("over_valid", int'(scan_valid), 0);
            check("over_ack", int'(move_ack), 0);
            check("over_player", int'(current_player), int'(BLUE));
            check("over_round", int'(round), exp_round);
            check("abandoned_cells", q.size(), 5);
            q.delete();

            game_over = 1'b0;
            start = 1'b1;
            move_req = 1'b1;
            for (int i = 0; i < 20; i++) begin
                scan_ready = ($urandom_range(0, 1) == 1);
                tick();
                start = 1'b0;
                check("over_hold_phase", int'(phase), int'(OVER));
                check("over_hold_ack", int'(move_ack), 0);
            end
            check("over_hold_round", int'(round), exp_round);
            check("over_hold_player", int'(current_player), int'(BLUE));

            reset = 1'b1;
            tick();
            check_reset_state("reset");
            reset = 1'b0;
            tick();
            tick();
            check("post_reset_phase", int'(phase), int'(IDLE));
            check("post_reset_ack", int'(move_ack), 0);
            move_req = 1'b0;
        end

        check("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
